// File: rtl/serial_pair_transmitter_msb_first.sv
// Parallel-to-serial source for two-operand bit-serial datapaths.
// A word pair (a, b) is accepted through a valid/ready handshake and shifted out
// MSB first on two lock-stepped 1-bit lanes with first/last framing. The exp_*
// outputs hold the unsigned compare result of the most recently accepted pair.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no word in flight, in_ready=1
// SHIFT | streaming one bit per cycle, bit_cnt_q = bits left incl. current
// GAP   | GAP_CYCLES idle cycles after the last bit, gap_cnt_q counts down
module serial_pair_transmitter_msb_first #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             ser_valid,
  output logic             ser_a,
  output logic             ser_b,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy,
  output logic             exp_less,
  output logic             exp_eq,
  output logic             exp_greater
);

  localparam int CW = $clog2(WIDTH + 1);
  // A zero-cycle gap still needs a 1-bit register to keep the declaration legal.
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam bit NO_GAP = (GAP_CYCLES == 0);
  localparam bit ONE_BIT = (WIDTH == 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic [WIDTH-1:0] sh_a_next, sh_b_next;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic             ser_valid_q, ser_valid_d;
  logic             ser_a_q, ser_a_d;
  logic             ser_b_q, ser_b_d;
  logic             ser_first_q, ser_first_d;
  logic             ser_last_q, ser_last_d;
  logic             busy_q, busy_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;
  logic             accept;

  // With no gap, the last-bit cycle can already take the next pair so words run back to back.
  assign in_ready = (state_q == S_IDLE) | (NO_GAP & (state_q == S_SHIFT) & ser_last_q);
  assign accept   = in_valid & in_ready;

  assign ser_valid   = ser_valid_q;
  assign ser_a       = ser_a_q;
  assign ser_b       = ser_b_q;
  assign ser_first   = ser_first_q;
  assign ser_last    = ser_last_q;
  assign busy        = busy_q;
  assign exp_less    = lt_q;
  assign exp_eq      = eq_q;
  assign exp_greater = gt_q;

  // Next-state, shift-register and registered-output decode; an accept overrides the FSM step.
  always_comb begin
    state_d     = state_q;
    sh_a_d      = sh_a_q;
    sh_b_d      = sh_b_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    ser_valid_d = 1'b0;
    ser_a_d     = 1'b0;
    ser_b_d     = 1'b0;
    ser_first_d = 1'b0;
    ser_last_d  = 1'b0;
    lt_d        = lt_q;
    eq_d        = eq_q;
    gt_d        = gt_q;
    sh_a_next   = sh_a_q << 1;
    sh_b_next   = sh_b_q << 1;

    case (state_q)
      S_IDLE: begin
        state_d = S_IDLE;
      end
      S_SHIFT: begin
        if (bit_cnt_q > CW'(1)) begin
          sh_a_d      = sh_a_next;
          sh_b_d      = sh_b_next;
          bit_cnt_d   = bit_cnt_q - CW'(1);
          ser_valid_d = 1'b1;
          ser_a_d     = sh_a_next[WIDTH-1];
          ser_b_d     = sh_b_next[WIDTH-1];
          ser_last_d  = (bit_cnt_q == CW'(2));
        end else begin
          bit_cnt_d = '0;
          if (NO_GAP) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_GAP;
            gap_cnt_d = GW'(GAP_CYCLES);
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q <= GW'(1)) begin
          state_d   = S_IDLE;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q - GW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (accept) begin
      state_d     = S_SHIFT;
      sh_a_d      = in_a;
      sh_b_d      = in_b;
      bit_cnt_d   = CW'(WIDTH);
      ser_valid_d = 1'b1;
      ser_a_d     = in_a[WIDTH-1];
      ser_b_d     = in_b[WIDTH-1];
      ser_first_d = 1'b1;
      ser_last_d  = ONE_BIT;
      lt_d        = (in_a < in_b);
      eq_d        = (in_a == in_b);
      gt_d        = (in_a > in_b);
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset; reset drops any word in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sh_a_q      <= '0;
      sh_b_q      <= '0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      ser_valid_q <= 1'b0;
      ser_a_q     <= 1'b0;
      ser_b_q     <= 1'b0;
      ser_first_q <= 1'b0;
      ser_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      lt_q        <= 1'b0;
      eq_q        <= 1'b1;
      gt_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_a_q      <= sh_a_d;
      sh_b_q      <= sh_b_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      ser_valid_q <= ser_valid_d;
      ser_a_q     <= ser_a_d;
      ser_b_q     <= ser_b_d;
      ser_first_q <= ser_first_d;
      ser_last_q  <= ser_last_d;
      busy_q      <= busy_d;
      lt_q        <= lt_d;
      eq_q        <= eq_d;
      gt_q        <= gt_d;
    end
  end

endmodule

// File: tb/tb_serial_pair_transmitter_msb_first.sv
// Bench for serial_pair_transmitter_msb_first.
// Instance 0: WIDTH=8 GAP=1, instance 1: WIDTH=8 GAP=0, instance 2: WIDTH=1 GAP=2.
// Accepted pairs go into a per-instance queue; a negedge monitor pops a pair on
// ser_first and checks every bit, the framing and exp_* against plain arithmetic,
// and runs its own MSB-first comparator over the serial lanes.
`timescale 1ns/1ps
module tb_serial_pair_transmitter_msb_first;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0] vld;
  logic [7:0] in_a_v [2];
  logic [7:0] in_b_v [2];
  logic       in_a_c, in_b_c;
  wire  [2:0] rdy, sv, sa, sb, sf, sl, by, lt, eq, gt;

  serial_pair_transmitter_msb_first #(.WIDTH(8), .GAP_CYCLES(1)) u_g1 (
    .clk(clk), .rst(rst), .in_valid(vld[0]), .in_ready(rdy[0]),
    .in_a(in_a_v[0]), .in_b(in_b_v[0]),
    .ser_valid(sv[0]), .ser_a(sa[0]), .ser_b(sb[0]), .ser_first(sf[0]), .ser_last(sl[0]),
    .busy(by[0]), .exp_less(lt[0]), .exp_eq(eq[0]), .exp_greater(gt[0]));

  serial_pair_transmitter_msb_first #(.WIDTH(8), .GAP_CYCLES(0)) u_g0 (
    .clk(clk), .rst(rst), .in_valid(vld[1]), .in_ready(rdy[1]),
    .in_a(in_a_v[1]), .in_b(in_b_v[1]),
    .ser_valid(sv[1]), .ser_a(sa[1]), .ser_b(sb[1]), .ser_first(sf[1]), .ser_last(sl[1]),
    .busy(by[1]), .exp_less(lt[1]), .exp_eq(eq[1]), .exp_greater(gt[1]));

  serial_pair_transmitter_msb_first #(.WIDTH(1), .GAP_CYCLES(2)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(vld[2]), .in_ready(rdy[2]),
    .in_a(in_a_c), .in_b(in_b_c),
    .ser_valid(sv[2]), .ser_a(sa[2]), .ser_b(sb[2]), .ser_first(sf[2]), .ser_last(sl[2]),
    .busy(by[2]), .exp_less(lt[2]), .exp_eq(eq[2]), .exp_greater(gt[2]));

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
  } pair_t;

  pair_t q0[$];
  pair_t q1[$];
  pair_t cur [2];
  bit    act [2];
  int    jj  [2];
  int    cmp [2];   // serial comparator: 0 equal so far, 1 a<b, 2 a>b

  task automatic mon_step(input int d);
    pair_t p;
    int    j;
    int    qs;
    if (rst) begin
      if (d == 0) q0.delete(); else q1.delete();
      act[d] = 0;
      return;
    end
    if (sv[d]) begin
      if (sf[d]) begin
        chk("word_unfinished_at_first", act[d], 0);
        qs = (d == 0) ? q0.size() : q1.size();
        chk("first_without_accept", qs != 0, 1);
        if (qs != 0) begin
          cur[d] = (d == 0) ? q0.pop_front() : q1.pop_front();
          act[d] = 1;
          jj[d]  = 0;
          cmp[d] = 0;
        end
      end
      if (act[d]) begin
        j = jj[d];
        p = cur[d];
        chk("ser_a_bit", sa[d], p.a[7-j]);
        chk("ser_b_bit", sb[d], p.b[7-j]);
        chk("ser_first_pos", sf[d], j == 0);
        chk("ser_last_pos", sl[d], j == 7);
        chk("exp_vs_pair", {lt[d], eq[d], gt[d]}, {p.a < p.b, p.a == p.b, p.a > p.b});
        if (cmp[d] == 0 && sa[d] != sb[d]) cmp[d] = sa[d] ? 2 : 1;
        if (j == 7) begin
          chk("serial_cmp_vs_exp", {lt[d], eq[d], gt[d]}, {cmp[d] == 1, cmp[d] == 0, cmp[d] == 2});
          act[d] = 0;
        end
        jj[d] = j + 1;
      end else begin
        chk("stray_bit", sv[d], 0);
      end
    end else begin
      chk("idle_lanes_zero", {sa[d], sb[d], sf[d], sl[d]}, 0);
      chk("bubble_mid_word", act[d], 0);
    end
    chk("exp_onehot", $countones({lt[d], eq[d], gt[d]}), 1);
    if (vld[d] && rdy[d]) begin
      if (d == 0) q0.push_back({in_a_v[0], in_b_v[0]});
      else        q1.push_back({in_a_v[1], in_b_v[1]});
    end
  endtask

  // Scoreboard monitor for both 8-bit instances.
  always @(negedge clk) begin
    mon_step(0);
    mon_step(1);
  end

  task automatic xfer(input int d, input logic [7:0] a, input logic [7:0] b, input bit drop);
    int t = 0;
    vld[d] = 1'b1;
    in_a_v[d] = a;
    in_b_v[d] = b;
    @(negedge clk);
    while (!rdy[d] && t < 100) begin
      t++;
      @(negedge clk);
    end
    chk("accept_timeout", rdy[d], 1);
    @(posedge clk);
    #1;
    if (drop) vld[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    int t = 0;
    @(negedge clk);
    while ((by[d] || !rdy[d]) && t < 100) begin
      t++;
      @(negedge clk);
    end
    chk("idle_timeout", by[d], 0);
  endtask

  logic [7:0] ka, kb, ra, rb;

  initial begin
    vld = '0;
    in_a_v[0] = '0; in_b_v[0] = '0;
    in_a_v[1] = '0; in_b_v[1] = '0;
    in_a_c = 1'b0;  in_b_c = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values on all instances
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("rst_lanes", {sv[d], sa[d], sb[d], sf[d], sl[d]}, 0);
      chk("rst_busy", by[d], 0);
      chk("rst_exp", {lt[d], eq[d], gt[d]}, 3'b010);
      chk("rst_ready", rdy[d], 1);
    end

    // A5 / 5A single word with exact cycle timing
    @(posedge clk); #1;
    ka = 8'hA5; kb = 8'h5A;
    vld[0] = 1'b1; in_a_v[0] = ka; in_b_v[0] = kb;
    @(negedge clk);
    chk("t2_ready_c0", rdy[0], 1);
    @(posedge clk); #1;
    vld[0] = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      chk("t2_valid", sv[0], c <= 8);
      chk("t2_first", sf[0], c == 1);
      chk("t2_last", sl[0], c == 8);
      chk("t2_ready", rdy[0], c >= 10);
      chk("t2_busy", by[0], c <= 9);
      if (c <= 8) begin
        chk("t2_ser_a", sa[0], ka[8-c]);
        chk("t2_ser_b", sb[0], kb[8-c]);
      end
      chk("t2_greater", gt[0], 1);
    end

    // Equal, then less with b's MSB set
    xfer(0, 8'h3C, 8'h3C, 1);
    @(negedge clk);
    chk("t3_eq", {lt[0], eq[0], gt[0]}, 3'b010);
    wait_idle(0);
    @(posedge clk); #1;
    xfer(0, 8'h7F, 8'h80, 1);
    @(negedge clk);
    chk("t3_less", {lt[0], eq[0], gt[0]}, 3'b100);
    wait_idle(0);
    @(posedge clk); #1;

    // Backpressure: in_valid pulsed during SHIFT is ignored
    xfer(0, 8'h96, 8'h21, 1);
    @(posedge clk); #1;
    vld[0] = 1'b1; in_a_v[0] = 8'h00; in_b_v[0] = 8'hFF;
    @(negedge clk);
    chk("t5_not_ready", rdy[0], 0);
    @(posedge clk); #1;
    vld[0] = 1'b0;
    @(negedge clk);
    chk("t5_exp_hold", {lt[0], eq[0], gt[0]}, 3'b001);
    wait_idle(0);
    @(posedge clk); #1;

    // GAP=0, three pairs with in_valid held high: continuous stream
    vld[1] = 1'b1; in_a_v[1] = 8'h11; in_b_v[1] = 8'hE2;
    @(negedge clk);
    chk("t4_ready_c0", rdy[1], 1);
    for (int c = 1; c <= 25; c++) begin
      @(posedge clk); #1;
      if (c == 1)  begin in_a_v[1] = 8'hC4; in_b_v[1] = 8'hC4; end
      if (c == 9)  begin in_a_v[1] = 8'hF0; in_b_v[1] = 8'h0F; end
      if (c == 17) vld[1] = 1'b0;
      @(negedge clk);
      chk("t4_valid", sv[1], c <= 24);
      chk("t4_ready", rdy[1], c == 8 || c == 16 || c == 24 || c == 25);
    end

    // Random pairs on the gapped instance
    for (int i = 0; i < 256; i++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? ra : 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        xfer(0, ra, rb, 1);
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end else begin
        xfer(0, ra, rb, 0);
      end
    end
    vld[0] = 1'b0;
    wait_idle(0);

    // Random back-to-back pairs on the gapless instance
    @(posedge clk); #1;
    for (int i = 0; i < 64; i++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? ra : 8'($urandom);
      xfer(1, ra, rb, i == 63);
    end
    wait_idle(1);

    // Reset during bit 4 of a word, then a fresh word
    @(posedge clk); #1;
    xfer(0, 8'hC3, 8'h12, 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t6_valid", sv[0], 0);
    chk("t6_busy", by[0], 0);
    chk("t6_ready", rdy[0], 1);
    chk("t6_exp", {lt[0], eq[0], gt[0]}, 3'b010);
    @(posedge clk); #1;
    xfer(0, 8'h81, 8'h7E, 0);
    vld[0] = 1'b0;
    @(negedge clk);
    chk("t6_fresh_first", {sv[0], sf[0], sa[0], sb[0]}, 4'b1110);
    wait_idle(0);

    // WIDTH=1, GAP=2: first and last coincide, then two gap cycles
    @(posedge clk); #1;
    vld[2] = 1'b1; in_a_c = 1'b1; in_b_c = 1'b0;
    @(negedge clk);
    chk("w1_ready_c0", rdy[2], 1);
    @(posedge clk); #1;
    vld[2] = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("w1_valid", sv[2], c == 1);
      chk("w1_first", sf[2], c == 1);
      chk("w1_last", sl[2], c == 1);
      chk("w1_ser_a", sa[2], c == 1);
      chk("w1_ser_b", sb[2], 0);
      chk("w1_ready", rdy[2], c == 4);
      chk("w1_exp", {lt[2], eq[2], gt[2]}, 3'b001);
    end
    @(posedge clk); #1;
    vld[2] = 1'b1; in_a_c = 1'b0; in_b_c = 1'b1;
    @(posedge clk); #1;
    vld[2] = 1'b0;
    @(negedge clk);
    chk("w1_second", {sv[2], sf[2], sl[2], sa[2], sb[2]}, 5'b11101);
    chk("w1_less", {lt[2], eq[2], gt[2]}, 3'b100);

    // Drain
    wait_idle(0);
    wait_idle(1);
    repeat (2) @(negedge clk);
    chk("sb_drained_0", q0.size(), 0);
    chk("sb_drained_1", q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
